// File: rtl/prog_load_ctrl.sv
// Program-load controller: holds the CPU in reset while the UART loader streams words into ROM/RAM.
// Define PROG_LOAD_TIMEOUT_EN to add the LOAD inactivity timeout that drives err_o.
module prog_load_ctrl #(
    parameter int unsigned DRAIN_CYC = 16,
    parameter int unsigned TO_W      = 24
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start_pg,
    input  logic        upg_wen_i,
    input  logic [14:0] upg_adr_i,
    input  logic [31:0] upg_dat_i,
    input  logic        upg_done_i,
    output logic        upg_rst_o,
    output logic        cpu_rst_o,
    output logic        rom_wen_o,
    output logic        ram_wen_o,
    output logic [13:0] wr_adr_o,
    output logic [31:0] wr_dat_o,
    output logic [13:0] rom_words_o,
    output logic [13:0] ram_words_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_DRAIN} state_t;

    localparam int unsigned     DC_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DC_W-1:0] DC_LAST   = DC_W'(DRAIN_CYC - 1);
    localparam logic [13:0]     WORDS_MAX = '1;

    state_t            state_q, state_d;
    logic [2:0]        sync_q;
    logic [2:0]        arm_q;
    logic [DC_W-1:0]   drain_cnt_q;
    logic              upg_rst_q, cpu_rst_q, busy_q, err_q;
    logic              rom_wen_q, ram_wen_q;
    logic [13:0]       wr_adr_q;
    logic [31:0]       wr_dat_q;
    logic [13:0]       words [2];
    logic              start_evt, load_enter, wr_fire, timeout;

    // sync_q[1] is the synchronized button, sync_q[2] its previous value. Edges are only
    // accepted once the pipe has refilled after reset, so a button held through reset is ignored.
    assign start_evt  = arm_q[2] & sync_q[1] & ~sync_q[2];
    assign load_enter = (state_q == ST_RUN) && start_evt;
    assign wr_fire    = (state_q == ST_LOAD) && upg_wen_i;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], start_pg};
            arm_q  <= {arm_q[1:0], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (start_evt) state_d = ST_LOAD;
            ST_LOAD:  if (upg_done_i || timeout) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_cnt_q == DC_LAST) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Status outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            upg_rst_q   <= 1'b1;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            upg_rst_q   <= (state_d != ST_LOAD);
            cpu_rst_q   <= (state_d != ST_RUN);
            busy_q      <= (state_d != ST_RUN);
            drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rom_wen_q <= 1'b0;
            ram_wen_q <= 1'b0;
            wr_adr_q  <= '0;
            wr_dat_q  <= '0;
        end else begin
            rom_wen_q <= wr_fire & ~upg_adr_i[14];
            ram_wen_q <= wr_fire &  upg_adr_i[14];
            if (wr_fire) begin
                wr_adr_q <= upg_adr_i[13:0];
                wr_dat_q <= upg_dat_i;
            end
        end
    end

    // Index 0 counts ROM words, index 1 counts RAM words.
    for (genvar gi = 0; gi < 2; gi++) begin : g_words
        localparam logic SEL_RAM = (gi == 1);
        logic [13:0] cnt_q;
        logic        hit;

        assign hit = wr_fire && (upg_adr_i[14] == SEL_RAM);

        always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (load_enter) begin
                cnt_q <= '0;
            end else if (hit && (cnt_q != WORDS_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign words[gi] = cnt_q;
    end

`ifdef PROG_LOAD_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign to_cnt_d = to_cnt_q + 1'b1;
    assign timeout  = (state_q == ST_LOAD) && !upg_wen_i && (to_cnt_d == '1);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if ((state_q != ST_LOAD) || upg_wen_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    // TO_W only sizes the timeout counter, which this build leaves out.
    assign timeout = 1'b0 & (TO_W > 0);
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (load_enter) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign upg_rst_o   = upg_rst_q;
    assign cpu_rst_o   = cpu_rst_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign rom_wen_o   = rom_wen_q;
    assign ram_wen_o   = ram_wen_q;
    assign wr_adr_o    = wr_adr_q;
    assign wr_dat_o    = wr_dat_q;
    assign rom_words_o = words[0];
    assign ram_words_o = words[1];

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Randomized scoreboard bench for prog_load_ctrl: the driver queues expected writes, a negedge monitor consumes them.
// Build with PROG_LOAD_TIMEOUT_EN defined to also exercise the timeout path (TO_W=4).
module tb_prog_load_ctrl;

    localparam int DRAIN = 16;
`ifdef PROG_LOAD_TIMEOUT_EN
    localparam int TOW = 4;
`else
    localparam int TOW = 24;
`endif
    localparam int WMAX = 16383;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        start_pg = 1'b0;
    logic        upg_wen_i = 1'b0;
    logic [14:0] upg_adr_i = '0;
    logic [31:0] upg_dat_i = '0;
    logic        upg_done_i = 1'b0;
    logic        upg_rst_o, cpu_rst_o, rom_wen_o, ram_wen_o, busy_o, err_o;
    logic [13:0] wr_adr_o, rom_words_o, ram_words_o;
    logic [31:0] wr_dat_o;

    prog_load_ctrl #(.DRAIN_CYC(DRAIN), .TO_W(TOW)) dut (
        .clock(clock), .rst(rst), .start_pg(start_pg),
        .upg_wen_i(upg_wen_i), .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
        .upg_done_i(upg_done_i), .upg_rst_o(upg_rst_o), .cpu_rst_o(cpu_rst_o),
        .rom_wen_o(rom_wen_o), .ram_wen_o(ram_wen_o), .wr_adr_o(wr_adr_o),
        .wr_dat_o(wr_dat_o), .rom_words_o(rom_words_o), .ram_words_o(ram_words_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_ram;
        logic [13:0] adr;
        logic [31:0] dat;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    bit  model_loading = 1'b0;
    int  model_rom = 0;
    int  model_ram = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each write pulse must match the oldest queued write, on the predicted cycle.
    always @(negedge clock) begin
        if (!rst && (rom_wen_o || ram_wen_o)) begin
            check("wen_exclusive", {31'd0, rom_wen_o & ram_wen_o}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: rom=%0b ram=%0b adr=0x%0h (cycle %0d)",
                         rom_wen_o, ram_wen_o, wr_adr_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("write: %s adr=0x%04h dat=0x%08h cycle=%0d",
                         ram_wen_o ? "RAM" : "ROM", wr_adr_o, wr_dat_o, cyc);
                check("wr_target", {31'd0, ram_wen_o}, {31'd0, mon_e.is_ram});
                check("wr_adr", {18'd0, wr_adr_o}, {18'd0, mon_e.adr});
                check("wr_dat", wr_dat_o, mon_e.dat);
                check("wr_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_wr(input logic [14:0] adr, input logic [31:0] dat);
        upg_wen_i = 1'b1;
        upg_adr_i = adr;
        upg_dat_i = dat;
        if (model_loading) begin
            exp_q.push_back('{is_ram: adr[14], adr: adr[13:0], dat: dat, cyc: cyc + 1});
            if (adr[14]) begin
                if (model_ram < WMAX) model_ram++;
            end else begin
                if (model_rom < WMAX) model_rom++;
            end
        end
    endtask

    task automatic wr(input logic [14:0] adr, input logic [31:0] dat);
        drive_wr(adr, dat);
        step();
        upg_wen_i = 1'b0;
    endtask

    task automatic do_start();
        start_pg = 1'b1;
        repeat (3) step();
        start_pg = 1'b0;
        model_loading = 1'b1;
        model_rom = 0;
        model_ram = 0;
        check("load_busy", {31'd0, busy_o}, 32'd1);
        check("load_upg_rst", {31'd0, upg_rst_o}, 32'd0);
        check("load_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("load_rom_words_clr", {18'd0, rom_words_o}, 32'd0);
        check("load_ram_words_clr", {18'd0, ram_words_o}, 32'd0);
        check("load_err_clr", {31'd0, err_o}, 32'd0);
    endtask

    // Called one step after the edge that entered DRAIN; wens pulsed here must be ignored.
    task automatic wait_drain(input bit exp_err);
        int n;
        check("drain_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        check("drain_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("drain_busy", {31'd0, busy_o}, 32'd1);
        n = 0;
        while (cpu_rst_o && n < DRAIN + 10) begin
            upg_wen_i = 1'($urandom_range(0, 1));
            upg_adr_i = 15'($urandom);
            step();
            n++;
        end
        upg_wen_i = 1'b0;
        $display("drain: %0d cycles", n);
        check("drain_len", n, DRAIN);
        check("run_busy", {31'd0, busy_o}, 32'd0);
        check("run_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        check("rom_words", {18'd0, rom_words_o}, model_rom);
        check("ram_words", {18'd0, ram_words_o}, model_ram);
        check("err", {31'd0, err_o}, {31'd0, exp_err});
    endtask

    task automatic finish_load(input bit with_wr);
        upg_done_i = 1'b1;
        if (with_wr) drive_wr({1'($urandom_range(0, 1)), 14'($urandom)}, $urandom);
        step();
        upg_done_i = 1'b0;
        upg_wen_i = 1'b0;
        model_loading = 1'b0;
        wait_drain(1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr, mid;

        repeat (3) step();
        check("rst_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        check("rst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("rst_wen", {30'd0, rom_wen_o, ram_wen_o}, 32'd0);
        check("rst_words", {4'd0, rom_words_o, ram_words_o}, 32'd0);
        check("rst_wr_adr", {18'd0, wr_adr_o}, 32'd0);
        check("rst_wr_dat", wr_dat_o, 32'd0);
        check("rst_busy_err", {30'd0, busy_o, err_o}, 32'd0);

        rst = 1'b0;
        step();
        check("cpu_rst_first_edge", {31'd0, cpu_rst_o}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("idle_outputs", {29'd0, cpu_rst_o, upg_rst_o, busy_o}, 32'b010);
            step();
        end

        // Directed load: 3 ROM words, 2 RAM words at 0x4005/0x4006.
        do_start();
        for (int i = 0; i < 3; i++) begin
            wr(15'(i), $urandom);
            repeat ($urandom_range(0, 2)) step();
        end
        wr(15'h4005, $urandom);
        repeat ($urandom_range(0, 2)) step();
        wr(15'h4006, $urandom);
        finish_load(1'b0);

        // Random loads: wens in RUN, a second start mid-LOAD, done together with a write.
        for (int it = 0; it < 3; it++) begin
            for (int j = 0; j < 4; j++) begin
                wr(15'($urandom), $urandom);
                step();
            end
            check("run_rom_hold", {18'd0, rom_words_o}, model_rom);
            check("run_ram_hold", {18'd0, ram_words_o}, model_ram);
            do_start();
            nwr = $urandom_range(8, 20);
            mid = nwr / 2;
            for (int k = 0; k < nwr; k++) begin
                if (k == mid) start_pg = 1'b1;
                if (k == mid + 3) start_pg = 1'b0;
                wr(15'($urandom), $urandom);
                repeat ($urandom_range(0, 2)) step();
                check("load_holds", {30'd0, busy_o, upg_rst_o}, 32'b10);
            end
            start_pg = 1'b0;
            finish_load(1'b1);
        end

        // Counter saturation on RAM words.
        do_start();
        wr(15'h0010, $urandom);
        for (int k = 0; k < WMAX + 6; k++) begin
            drive_wr({1'b1, 14'(k)}, $urandom);
            step();
        end
        upg_wen_i = 1'b0;
        finish_load(1'b0);

        // Reset five cycles into LOAD, with a strobe pending at the reset edge.
        repeat (3) step();
        do_start();
        repeat (4) step();
        model_loading = 1'b0;
        drive_wr(15'($urandom), $urandom);
        rst = 1'b1;
        step();
        upg_wen_i = 1'b0;
        model_rom = 0;
        model_ram = 0;
        check("midrst_cpu_rst", {31'd0, cpu_rst_o}, 32'd1);
        check("midrst_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_wen", {30'd0, rom_wen_o, ram_wen_o}, 32'd0);
        check("midrst_words", {4'd0, rom_words_o, ram_words_o}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("postrst_cpu_rst", {31'd0, cpu_rst_o}, 32'd0);
        repeat (5) step();
        check("postrst_busy", {31'd0, busy_o}, 32'd0);

        // Button held through reset must not start a load.
        start_pg = 1'b1;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (8) step();
        check("held_button_busy", {31'd0, busy_o}, 32'd0);
        start_pg = 1'b0;
        repeat (3) step();
        do_start();
        wr(15'h4001, $urandom);
        finish_load(1'b0);

`ifdef PROG_LOAD_TIMEOUT_EN
        begin
            int n;
            do_start();
            n = 0;
            while (!err_o && n < 40) begin
                step();
                n++;
            end
            $display("timeout: err after %0d idle cycles", n);
            check("timeout_len", n, 15);
            model_loading = 1'b0;
            wait_drain(1'b1);
            repeat (2) step();
            do_start();
            finish_load(1'b0);
        end
`endif

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
